// File: rtl/axil_pkg.sv
// AXI-Lite response codes and the byte-strobe type shared by the AXI-Lite
// slaves.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef logic [3:0] strb_t;

   function automatic logic [1:0] resp_of(input logic err);
      return err ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with per-byte write enables. The read port is
// registered and read-first, so it maps onto a block RAM.
module ram_sdp_be #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic [DATA_W/8-1:0] we,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                re,
   input  logic [ADDR_W-1:0]   raddr,
   output logic [DATA_W-1:0]   rdata
);

   localparam int NB = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write and read in the same clocked block; the non-blocking write makes a
   // same-address read return the old word.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axil_ram_slave.sv
// AXI-Lite slave in front of a byte-writable block RAM. The write and read
// paths are fully independent.
module axil_ram_slave
   import axil_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
   parameter int                    MEM_WORDS  = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [2:0]            s_axil_awprot,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [31:0]           s_axil_wdata,
   input  logic [3:0]            s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]            s_axil_arprot,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [31:0]           s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   // Byte span of the RAM, one bit wider than the address so it never wraps.
   localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(64'(MEM_WORDS) << 2);

   logic             aw_held;
   logic             w_held;
   logic [IDX_W-1:0] aw_idx_p0;
   logic             aw_err_p0;
   logic [31:0]      wdata_p0;
   strb_t            wstrb_p0;
   logic             rd_ok_p1;
   logic [31:0]      ram_q;
   logic             unused_prot;

   logic                  aw_hs, w_hs, ar_hs, wr_fire;
   logic                  aw_in, ar_in;
   logic [ADDR_WIDTH-1:0] aw_off, ar_off;
   strb_t                 ram_we;
   logic                  ram_re;

   assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

   assign s_axil_awready = !aw_held;
   assign s_axil_wready  = !w_held;
   assign s_axil_arready = !s_axil_rvalid;

   assign aw_hs = s_axil_awvalid && s_axil_awready;
   assign w_hs  = s_axil_wvalid && s_axil_wready;
   assign ar_hs = s_axil_arvalid && s_axil_arready;

   // An address below the base wraps to a huge offset and also fails the span test.
   assign aw_off = s_axil_awaddr - BASE_ADDR;
   assign ar_off = s_axil_araddr - BASE_ADDR;
   assign aw_in  = (s_axil_awaddr >= BASE_ADDR) && ({1'b0, aw_off} < SPAN);
   assign ar_in  = (s_axil_araddr >= BASE_ADDR) && ({1'b0, ar_off} < SPAN);

   // Reset suppresses the fire so an abandoned write never reaches the RAM.
   assign wr_fire = aw_held && w_held && !s_axil_bvalid && !rst;
   assign ram_we  = (wr_fire && !aw_err_p0) ? wstrb_p0 : '0;
   assign ram_re  = ar_hs && ar_in;

   // Stage p0: AW and W latched independently until both are present.
   always_ff @(posedge clk) begin
      if (aw_hs) begin
         aw_idx_p0 <= aw_off[IDX_W+1:2];
         aw_err_p0 <= !aw_in;
      end
      if (w_hs) begin
         wdata_p0 <= s_axil_wdata;
         wstrb_p0 <= s_axil_wstrb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         s_axil_bvalid <= 1'b0;
         s_axil_bresp  <= RESP_OKAY;
      end else begin
         if (aw_hs) aw_held <= 1'b1;
         if (w_hs)  w_held  <= 1'b1;
         if (wr_fire) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= resp_of(aw_err_p0);
         end else if (s_axil_bvalid && s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
         end
      end
   end

   // Stage p1: read response; rdata is masked to zero unless the read hit the RAM.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_axil_rvalid <= 1'b0;
         s_axil_rresp  <= RESP_OKAY;
         rd_ok_p1      <= 1'b0;
      end else if (ar_hs) begin
         s_axil_rvalid <= 1'b1;
         s_axil_rresp  <= resp_of(!ar_in);
         rd_ok_p1      <= ar_in;
      end else if (s_axil_rvalid && s_axil_rready) begin
         s_axil_rvalid <= 1'b0;
      end
   end

   assign s_axil_rdata = rd_ok_p1 ? ram_q : 32'h0;

   ram_sdp_be #(
      .DATA_W (32),
      .DEPTH  (MEM_WORDS),
      .ADDR_W (IDX_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (aw_idx_p0),
      .wdata (wdata_p0),
      .re    (ram_re),
      .raddr (ar_off[IDX_W+1:2]),
      .rdata (ram_q)
   );

endmodule

// File: doc/axil_ram_slave.md
AXIL_RAM_SLAVE -- requirements
Module: axil_ram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: width of the AXI-Lite address buses.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of RAM word 0.
REQ-003 Parameter MEM_WORDS, default 4096: RAM depth in 32-bit words (power of two).
REQ-004 clk  in  1: single clock; all logic on rising edge.
REQ-005 rst  in  1: reset, synchronous and active-high.
REQ-006 s_axil_awaddr in ADDR_WIDTH; s_axil_awprot in 3 (ignored); s_axil_awvalid in 1; s_axil_awready out 1: write-address channel.
REQ-007 s_axil_wdata in 32; s_axil_wstrb in 4; s_axil_wvalid in 1; s_axil_wready out 1: write-data channel.
REQ-008 s_axil_bresp out 2; s_axil_bvalid out 1; s_axil_bready in 1: write-response channel.
REQ-009 s_axil_araddr in ADDR_WIDTH; s_axil_arprot in 3 (ignored); s_axil_arvalid in 1; s_axil_arready out 1: read-address channel.
REQ-010 s_axil_rdata out 32; s_axil_rresp out 2; s_axil_rvalid out 1; s_axil_rready in 1: read-data channel.

Function
REQ-011 The block SHALL act as an AXI-Lite slave that consumes the processor data-side AXI-Lite master port directly.
REQ-012 A handshake on any channel SHALL occur on a cycle where valid and ready are both high.
REQ-013 Write path: s_axil_awready SHALL equal !aw_held and s_axil_wready SHALL equal !w_held; AW and W SHALL be accepted independently, in either order or in the same cycle, and latched.
REQ-014 The write SHALL fire in a cycle where aw_held && w_held && !s_axil_bvalid; at the end of that cycle the RAM is updated, aw_held and w_held clear, and bvalid sets.
REQ-015 Write latency: AW and W handshakes in cycle N -> bvalid high in cycle N+2; bvalid SHALL stay high with stable bresp until the bready handshake.
REQ-016 A new AW/W SHALL be accepted while bvalid is high, but the write SHALL NOT fire until bvalid has cleared.
REQ-017 Only bytes with wstrb[i]=1 SHALL be written; wstrb=4'b0000 SHALL return OKAY with the RAM unchanged.
REQ-018 Read path: s_axil_arready SHALL equal !s_axil_rvalid; an AR handshake in cycle N SHALL give rvalid high with data in cycle N+1.
REQ-019 rdata and rresp SHALL stay stable while rvalid && !rready; the RAM read port SHALL be enabled only on the AR handshake.
REQ-020 Word index SHALL be (addr - BASE_ADDR) >> 2; the low two address bits SHALL be ignored.
REQ-021 An address outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS) SHALL return SLVERR; an out-of-range write leaves the RAM unchanged; an out-of-range read returns rdata = 0.
REQ-022 An in-range access SHALL return OKAY (2'b00).
REQ-023 A read and a write to the same word in the same cycle SHALL be read-first: the read returns the pre-write data.
REQ-024 Read and write paths SHALL be independent; neither SHALL stall the other.

Reset
REQ-025 When rst is high at a clock edge: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, aw_held=0, w_held=0.
REQ-026 Reset mid-transaction SHALL abandon the pending write (the RAM is not written) and any pending response; RAM contents SHALL NOT be cleared.

Structure
REQ-027 Shared package axil_pkg SHALL hold the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10, plus a typedef for a 4-bit strobe.
REQ-028 Storage SHALL be a sub-module ram_sdp_be: simple dual-port RAM with per-byte write enables, a synchronous read-first read port, and an inferable block RAM.

Verification
REQ-029 AW and W in the same cycle, addr BASE+0x10, data 32'hDEADBEEF, strb 4'hF, bready=1 -> bvalid in cycle N+2 with OKAY; a read of 0x10 returns DEADBEEF, OKAY, rvalid at AR+1.
REQ-030 W three cycles before AW (data 32'h11223344, strb 4'b0101) over existing 0xFFFFFFFF -> read returns 32'hFF22FF44.
REQ-031 Read at BASE+4*MEM_WORDS -> rresp SLVERR, rdata 0; write to the same address -> bresp SLVERR, and a read of word 0 is unchanged.
REQ-032 rready held low 5 cycles after rvalid -> rdata stable, arready low throughout; a second AR is accepted only after the rready handshake.
REQ-033 bready low while a second AW/W pair arrives -> both are latched, no second write until B handshake, then second bvalid follows 2 cycles later.
REQ-034 rst asserted with aw_held=1, w_held=0 -> all outputs at reset values next cycle; subsequent reads show target word unchanged.
